// File: rtl/pdp8_uart_pkg.sv
// Shared constants and FSM state encodings for the PDP-8 console UART.
package pdp8_uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/pdp8_uart_xcvr_if.sv
// Console-side handshake bundle between the PDP-8 TTY interface and the UART.
interface pdp8_uart_xcvr_if;
  import pdp8_uart_pkg::*;

  // Four-phase req/ack: the console raises req (with data stable for tx),
  // the UART raises ack one clk later and holds it until req drops; a new
  // transfer is only accepted once ack has returned low.
  logic                 tx_req;
  logic                 tx_ack;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_empty;
  logic                 rx_req;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_empty;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_req, tx_data, rx_req,
    input  tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_req, tx_data, rx_req,
    output tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/pdp8_uart_rx.sv
// Oversampling 8N1 receiver: synchroniser, framing FSM, shifter and error pulses.
module pdp8_uart_rx
  import pdp8_uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_clk,
  input  logic                 rx_in,
  input  logic                 accept_ok,
  output logic [DATA_BITS-1:0] rx_char,
  output logic                 char_done,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);

  rx_state_e            state;
  logic [1:0]           rx_sync;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic                 rxs;

  assign rxs       = rx_sync[1];
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_IDLE;
      rx_sync   <= 2'b11;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      rx_char   <= '0;
      char_done <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], rx_in};
      char_done <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_clk) begin
        case (state)
          RX_IDLE: if (!rxs) begin
            state    <= RX_START;
            tick_cnt <= '0;
          end
          // Half a bit after the falling edge: confirms a real start bit.
          RX_START: if (tick_cnt == TW'(OVERSAMPLE/2 - 1)) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          RX_DATA: if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
            tick_cnt <= '0;
            rx_char  <= {rxs, rx_char[DATA_BITS-1:1]};
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= RX_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          RX_STOP: if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
            tick_cnt <= '0;
            if (rxs) begin
              char_done <= accept_ok;
              overrun   <= !accept_ok;
              state     <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          RX_WAIT_HIGH: if (rxs) state <= RX_IDLE;
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pdp8_uart_xcvr.sv
// PDP-8 console UART top: TX FSM, console handshakes, and the receiver instance.
module pdp8_uart_xcvr
  import pdp8_uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_clk,
  input  logic              rx_clk,
  input  logic              rx_in,
  output logic              tx_out,
  pdp8_uart_xcvr_if.slave   con,
  output logic [2:0]        tx_state_dbg,
  output logic [2:0]        rx_state_dbg
);

  tx_state_e            tx_state;
  logic                 tx_ack_q, tx_empty_q, tx_pending;
  logic [DATA_BITS-1:0] tx_shift;
  logic [2:0]           tx_bit_cnt;
  logic                 tx_stop_cnt;
  logic                 tx_take;

  logic                 rx_ack_q, rx_empty_q, rx_take;
  logic [DATA_BITS-1:0] rx_data_q, rx_char;
  logic                 char_done, frame_err, overrun;

  // tx_empty implies the FSM is idle with nothing waiting to start.
  assign tx_take      = con.tx_req & ~tx_ack_q & tx_empty_q;
  assign rx_take      = con.rx_req & ~rx_ack_q & ~rx_empty_q;
  assign con.tx_ack   = tx_ack_q;
  assign con.tx_empty = tx_empty_q;
  assign con.rx_ack   = rx_ack_q;
  assign con.rx_empty = rx_empty_q;
  assign con.rx_data  = rx_data_q;
  assign con.rx_frame_err = frame_err;
  assign con.rx_overrun   = overrun;
  assign tx_state_dbg = tx_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_out      <= 1'b1;
      tx_ack_q    <= 1'b0;
      tx_empty_q  <= 1'b1;
      tx_pending  <= 1'b0;
      tx_shift    <= '0;
      tx_bit_cnt  <= '0;
      tx_stop_cnt <= 1'b0;
    end else begin
      if (tx_take) begin
        tx_shift   <= con.tx_data;
        tx_ack_q   <= 1'b1;
        tx_empty_q <= 1'b0;
        tx_pending <= 1'b1;
      end else if (!con.tx_req) begin
        tx_ack_q <= 1'b0;
      end
      if (tx_clk) begin
        case (tx_state)
          TX_IDLE: if (tx_pending) begin
            tx_state   <= TX_START;
            tx_out     <= 1'b0;
            tx_pending <= 1'b0;
          end
          TX_START: begin
            tx_state   <= TX_DATA;
            tx_out     <= tx_shift[0];
            tx_shift   <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit_cnt <= '0;
          end
          TX_DATA: if (tx_bit_cnt == 3'(DATA_BITS - 1)) begin
            tx_state    <= TX_STOP;
            tx_out      <= 1'b1;
            tx_stop_cnt <= 1'b0;
          end else begin
            tx_out     <= tx_shift[0];
            tx_shift   <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit_cnt <= tx_bit_cnt + 1'b1;
          end
          TX_STOP: if (tx_stop_cnt == 1'(STOP_BITS - 1)) begin
            tx_state   <= TX_IDLE;
            tx_empty_q <= 1'b1;
          end else begin
            tx_stop_cnt <= tx_stop_cnt + 1'b1;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // A consume on the stop-sample clk frees the holder, so the receiver
  // accepts the new character instead of flagging an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ack_q   <= 1'b0;
      rx_empty_q <= 1'b1;
      rx_data_q  <= '0;
    end else begin
      if (rx_take) begin
        rx_ack_q   <= 1'b1;
        rx_empty_q <= 1'b1;
      end else if (!con.rx_req) begin
        rx_ack_q <= 1'b0;
      end
      if (char_done) begin
        rx_data_q  <= rx_char;
        rx_empty_q <= 1'b0;
      end
    end
  end

  pdp8_uart_rx #(.OVERSAMPLE(OVERSAMPLE)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_clk    (rx_clk),
    .rx_in     (rx_in),
    .accept_ok (rx_empty_q | rx_take),
    .rx_char   (rx_char),
    .char_done (char_done),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_dbg (rx_state_dbg)
  );

endmodule

// File: tb/tb_pdp8_uart_xcvr.sv
// Directed bench for the PDP-8 console UART: TX framing, RX handshake, overrun, framing error, glitch, reset.
module tb_pdp8_uart_xcvr;
  import pdp8_uart_pkg::*;

  localparam int TX_BIT = 16;  // clks per tx bit (tx_clk every 16 clks)
  localparam int RX_BIT = 32;  // clks per rx bit (rx_clk every 2 clks, 16 ticks/bit)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_clk = 1'b0;
  logic rx_clk = 1'b0;
  logic rx_in = 1'b1;
  logic tx_out;
  logic [2:0] tx_state_dbg, rx_state_dbg;
  int unsigned baud_cnt = 0;
  int total = 0;
  int bad = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;

  pdp8_uart_xcvr_if con ();

  pdp8_uart_xcvr #(.OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_clk       (tx_clk),
    .rx_clk       (rx_clk),
    .rx_in        (rx_in),
    .tx_out       (tx_out),
    .con          (con),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // Clock and baud enables
  always #5 clk = ~clk;

  always @(negedge clk) begin
    baud_cnt = baud_cnt + 1;
    tx_clk = (baud_cnt % TX_BIT) == 0;
    rx_clk = baud_cnt[0];
  end

  // Pulse counters; each pulse is high for exactly one posedge sample.
  always @(posedge clk) begin
    if (!reset) begin
      if (con.rx_overrun === 1'b1) ovr_cnt++;
      if (con.rx_frame_err === 1'b1) fe_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] ch, input logic stop);
    rx_in = 1'b0;
    step(RX_BIT);
    for (int i = 0; i < 8; i++) begin
      rx_in = ch[i];
      step(RX_BIT);
    end
    rx_in = stop;
    step(RX_BIT);
  endtask

  task automatic tx_send(input logic [7:0] ch);
    con.tx_data = ch;
    con.tx_req  = 1'b1;
    step(1);
    check("tx_ack_rise", con.tx_ack, 1);
    check("tx_empty_busy", con.tx_empty, 0);
    con.tx_req = 1'b0;
    step(1);
    check("tx_ack_fall", con.tx_ack, 0);
  endtask

  task automatic check_tx_frame(input logic [7:0] ch);
    int n;
    n = 0;
    while (tx_out !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    check("tx_start_edge", tx_out, 0);
    step(TX_BIT / 2);
    check("tx_start_bit", tx_out, 0);
    for (int i = 0; i < 8; i++) begin
      step(TX_BIT);
      check($sformatf("tx_data_bit%0d", i), tx_out, ch[i]);
    end
    step(TX_BIT);
    check("tx_stop_bit", tx_out, 1);
    check("tx_empty_in_stop", con.tx_empty, 0);
    step(TX_BIT);
    check("tx_empty_after", con.tx_empty, 1);
    check("tx_idle_line", tx_out, 1);
  endtask

  task automatic rx_drain(input logic [7:0] exp_data);
    con.rx_req = 1'b1;
    step(1);
    check("rx_ack_rise", con.rx_ack, 1);
    check("rx_empty_taken", con.rx_empty, 1);
    check("rx_data_kept", con.rx_data, exp_data);
    con.rx_req = 1'b0;
    step(1);
    check("rx_ack_fall", con.rx_ack, 0);
  endtask

  initial begin
    con.tx_req  = 1'b0;
    con.tx_data = 8'h00;
    con.rx_req  = 1'b0;
    step(3);

    // Reset values
    check("rst_tx_out", tx_out, 1);
    check("rst_tx_ack", con.tx_ack, 0);
    check("rst_tx_empty", con.tx_empty, 1);
    check("rst_rx_ack", con.rx_ack, 0);
    check("rst_rx_empty", con.rx_empty, 1);
    check("rst_rx_data", con.rx_data, 0);
    check("rst_frame_err", con.rx_frame_err, 0);
    check("rst_overrun", con.rx_overrun, 0);
    reset = 1'b0;
    step(2);

    // 1: transmit 'A'
    tx_send(8'h41);
    check_tx_frame(8'h41);

    // 2: receive 0x55 and drain it; rx_req while empty is ignored
    con.rx_req = 1'b1;
    step(1);
    check("rx_req_when_empty", con.rx_ack, 0);
    con.rx_req = 1'b0;
    step(1);
    send_rx(8'h55, 1'b1);
    step(2);
    check("rx55_empty", con.rx_empty, 0);
    check("rx55_data", con.rx_data, 8'h55);
    rx_drain(8'h55);

    // 3: two characters, no drain in between
    send_rx(8'h31, 1'b1);
    send_rx(8'h32, 1'b1);
    step(4);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_data", con.rx_data, 8'h31);
    check("ovr_empty", con.rx_empty, 0);
    rx_drain(8'h31);

    // 4: framing error, line low 3 bit times, then a good character
    send_rx(8'hA5, 1'b0);
    step(3 * RX_BIT);
    rx_in = 1'b1;
    step(2 * RX_BIT);
    check("fe_count", fe_cnt, 1);
    check("fe_empty", con.rx_empty, 1);
    check("fe_data_unchanged", con.rx_data, 8'h31);
    send_rx(8'h0D, 1'b1);
    step(4);
    check("after_fe_empty", con.rx_empty, 0);
    check("after_fe_data", con.rx_data, 8'h0D);
    check("after_fe_count", fe_cnt, 1);
    rx_drain(8'h0D);

    // 5: quarter-bit glitch
    rx_in = 1'b0;
    step(RX_BIT / 4);
    rx_in = 1'b1;
    step(2 * RX_BIT);
    check("glitch_empty", con.rx_empty, 1);
    check("glitch_fe", fe_cnt, 1);
    check("glitch_ovr", ovr_cnt, 1);
    check("glitch_rx_state", rx_state_dbg, RX_IDLE);

    // 6: reset mid-transmit, then a clean frame
    tx_send(8'hFF);
    step(5 * TX_BIT);
    check("pre_reset_busy", con.tx_empty, 0);
    reset = 1'b1;
    step(1);
    check("mid_rst_tx_out", tx_out, 1);
    check("mid_rst_tx_empty", con.tx_empty, 1);
    check("mid_rst_tx_state", tx_state_dbg, TX_IDLE);
    reset = 1'b0;
    step(2);
    tx_send(8'h0A);
    check_tx_frame(8'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
